// File: rtl/bsg_fifo_1r1w_large_nway.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_1r1w_large_nway
// Brief    : Deep 1R1W FIFO on a single-ported line memory. Words are packed
//            ways_p to a line, spilled to memory or bypassed straight into
//            ways_p two-entry output FIFOs read in rotating order.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_fifo_1r1w_large_nway #(
   parameter int width_p       = 128,
   parameter int els_p         = 512,
   parameter int ways_p        = 4,
   parameter int almost_full_p = els_p
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic [width_p-1:0]                       data_i,
   input  logic                                     v_i,
   output logic                                     ready_o,
   output logic [width_p-1:0]                       data_o,
   output logic                                     v_o,
   input  logic                                     yumi_i,
   output logic [$clog2(els_p+3*ways_p+1)-1:0]      count_o,
   output logic                                     almost_full_o
);

   localparam int c_lines = els_p / ways_p;
   localparam int c_aw    = (c_lines > 1) ? $clog2(c_lines) : 1;
   localparam int c_ww    = $clog2(ways_p);
   localparam int c_sw    = $clog2(ways_p + 1);
   localparam int c_cw    = $clog2(els_p + 3*ways_p + 1);

   // SIPO packing stage, entry 0 is the oldest word
   logic [width_p-1:0]         r_sipo [ways_p];
   logic [c_sw-1:0]            r_sipo_cnt;
   logic [width_p-1:0]         w_sipo_nxt [ways_p];
   logic [c_sw:0]              w_src;
   logic [c_ww-1:0]            w_ins;

   // line memory and its pointers (wrap bit separates full from empty)
   logic [ways_p*width_p-1:0]  r_mem [c_lines];
   logic [ways_p*width_p-1:0]  r_mem_rdata;
   logic [ways_p*width_p-1:0]  w_line;
   logic [c_aw-1:0]            r_wptr, r_rptr;
   logic                       r_wwrap, r_rwrap;
   logic                       r_rd_inflight;

   // little output FIFOs, slot 0 is the head
   logic [width_p-1:0]         r_lf_data [ways_p][2];
   logic [1:0]                 r_lf_cnt  [ways_p];
   logic [c_ww-1:0]            r_wr_rot, r_rd_rot;
   logic [ways_p-1:0]          w_room;
   logic [ways_p-1:0]          w_lf_push, w_lf_pop;
   logic [width_p-1:0]         w_lf_pdata [ways_p];
   logic [c_ww-1:0]            w_lane [ways_p];

   logic [c_cw-1:0]            r_count;

   logic                       w_mem_empty, w_mem_full, w_all_room;
   logic                       w_bypass, w_spill, w_emerg, w_deq, w_mem_rd;
   logic                       w_sipo_full, w_accept, w_run_on;
   logic [c_sw-1:0]            w_run, w_bp_n, w_consume;

   assign w_mem_empty = (r_wptr == r_rptr) && (r_wwrap == r_rwrap);
   assign w_mem_full  = (r_wptr == r_rptr) && (r_wwrap != r_rwrap);
   assign w_all_room  = &w_room;
   assign w_sipo_full = (r_sipo_cnt == c_sw'(ways_p));

   // room flags and the run of consecutive roomy FIFOs from the rotate pointer
   always_comb begin
      w_room   = '0;
      w_run    = '0;
      w_run_on = 1'b1;
      for (int f = 0; f < ways_p; f++) begin
         w_room[f] = (r_lf_cnt[f] != 2'd2);
      end
      for (int j = 0; j < ways_p; j++) begin
         if (w_run_on && w_room[c_ww'(r_wr_rot + c_ww'(j))]) begin
            w_run = w_run + 1'b1;
         end else begin
            w_run_on = 1'b0;
         end
      end
   end

   // memory arbitration: bypass, emergency read, spill, normal read
   assign w_bypass  = w_mem_empty && !r_rd_inflight && w_room[r_wr_rot] && (r_sipo_cnt != '0);
   assign w_bp_n    = (w_run < r_sipo_cnt) ? w_run : r_sipo_cnt;
   assign w_emerg   = !w_mem_empty && !r_rd_inflight && w_all_room;
   assign w_spill   = w_sipo_full && !w_mem_full && !w_bypass && !w_emerg;
   assign w_deq     = !w_spill && !w_mem_empty && !r_rd_inflight && w_all_room;
   assign w_mem_rd  = w_emerg || w_deq;
   assign w_consume = w_bypass ? w_bp_n : (w_spill ? c_sw'(ways_p) : '0);

   // ready depends only on registered state, never on v_i
   assign ready_o  = !w_sipo_full || w_bypass || w_spill;
   assign w_accept = v_i && ready_o;

   // SIPO next state: drop consumed words from the front, append the new word
   always_comb begin
      w_src = '0;
      w_ins = c_ww'(r_sipo_cnt - w_consume);
      for (int i = 0; i < ways_p; i++) begin
         w_sipo_nxt[i] = r_sipo[i];
      end
      for (int i = 0; i < ways_p; i++) begin
         w_src = (c_sw+1)'(i) + {1'b0, w_consume};
         if (w_src < (c_sw+1)'(ways_p)) begin
            w_sipo_nxt[i] = r_sipo[w_src[c_ww-1:0]];
         end
      end
      if (w_accept) begin
         w_sipo_nxt[w_ins] = data_i;
      end
   end

   // SIPO storage and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_sipo_cnt <= '0;
      end else begin
         r_sipo_cnt <= r_sipo_cnt - w_consume + c_sw'(w_accept);
      end
      for (int i = 0; i < ways_p; i++) begin
         r_sipo[i] <= w_sipo_nxt[i];
      end
   end

   // spill line is the SIPO contents, oldest word in lane 0
   always_comb begin
      w_line = '0;
      for (int j = 0; j < ways_p; j++) begin
         w_line[j*width_p +: width_p] = r_sipo[j];
      end
   end

   // single-ported line memory: one write or one read per cycle
   always_ff @(posedge clk_i) begin
      if (w_spill) begin
         r_mem[r_wptr] <= w_line;
      end
      if (w_mem_rd) begin
         r_mem_rdata <= r_mem[r_rptr];
      end
   end

   // memory pointers and the read-in-flight flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_wwrap       <= 1'b0;
         r_rwrap       <= 1'b0;
         r_rd_inflight <= 1'b0;
      end else begin
         r_rd_inflight <= w_mem_rd;
         if (w_spill) begin
            if (r_wptr == c_aw'(c_lines - 1)) begin
               r_wptr  <= '0;
               r_wwrap <= !r_wwrap;
            end else begin
               r_wptr <= r_wptr + 1'b1;
            end
         end
         if (w_mem_rd) begin
            if (r_rptr == c_aw'(c_lines - 1)) begin
               r_rptr  <= '0;
               r_rwrap <= !r_rwrap;
            end else begin
               r_rptr <= r_rptr + 1'b1;
            end
         end
      end
   end

   // route returning lines or bypassed words to the little FIFOs by lane
   always_comb begin
      for (int f = 0; f < ways_p; f++) begin
         w_lane[f]     = c_ww'(f) - r_wr_rot;
         w_lf_push[f]  = 1'b0;
         w_lf_pdata[f] = '0;
         w_lf_pop[f]   = yumi_i && (r_rd_rot == c_ww'(f));
         if (r_rd_inflight) begin
            w_lf_push[f]  = 1'b1;
            w_lf_pdata[f] = r_mem_rdata[int'(w_lane[f])*width_p +: width_p];
         end else if (w_bypass && (c_sw'(w_lane[f]) < w_bp_n)) begin
            w_lf_push[f]  = 1'b1;
            w_lf_pdata[f] = r_sipo[w_lane[f]];
         end
      end
   end

   // two-entry little FIFOs
   always_ff @(posedge clk_i) begin
      for (int f = 0; f < ways_p; f++) begin
         if (reset_i) begin
            r_lf_cnt[f] <= 2'd0;
         end else begin
            case ({w_lf_push[f], w_lf_pop[f]})
               2'b10: begin
                  r_lf_data[f][r_lf_cnt[f][0]] <= w_lf_pdata[f];
                  r_lf_cnt[f]                  <= r_lf_cnt[f] + 2'd1;
               end
               2'b01: begin
                  r_lf_data[f][0] <= r_lf_data[f][1];
                  r_lf_cnt[f]     <= r_lf_cnt[f] - 2'd1;
               end
               2'b11: begin
                  if (r_lf_cnt[f] == 2'd1) begin
                     r_lf_data[f][0] <= w_lf_pdata[f];
                  end else begin
                     r_lf_data[f][0] <= r_lf_data[f][1];
                     r_lf_data[f][1] <= w_lf_pdata[f];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // write rotation advances by words bypassed, read rotation by words consumed
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_rot <= '0;
         r_rd_rot <= '0;
      end else begin
         if (w_bypass) begin
            r_wr_rot <= r_wr_rot + w_bp_n[c_ww-1:0];
         end
         if (yumi_i) begin
            r_rd_rot <= r_rd_rot + 1'b1;
         end
      end
   end

   // occupancy counter
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count <= '0;
      end else begin
         case ({w_accept, yumi_i})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // consuming an empty head is a consumer protocol violation
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(yumi_i && !v_o)) else $error("bsg_fifo_1r1w_large_nway: yumi_i asserted without v_o");
      end
   end

   assign data_o        = r_lf_data[r_rd_rot][0];
   assign v_o           = (r_lf_cnt[r_rd_rot] != 2'd0);
   assign count_o       = r_count;
   assign almost_full_o = (r_count >= c_cw'(almost_full_p));

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifo_1r1w_large_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_fifo_1r1w_large_nway
// Brief    : Directed + randomized bench with a queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_fifo_1r1w_large_nway;

   localparam int W    = 128;
   localparam int ELS  = 512;
   localparam int WAYS = 4;
   localparam int AF   = 512;
   localparam int CW   = $clog2(ELS + 3*WAYS + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  din, dout;
   logic          v_in, ready, v_out, yumi, af;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   bsg_fifo_1r1w_large_nway #(
      .width_p(W), .els_p(ELS), .ways_p(WAYS), .almost_full_p(AF)
   ) dut (
      .clk_i(clk), .reset_i(reset), .data_i(din), .v_i(v_in), .ready_o(ready),
      .data_o(dout), .v_o(v_out), .yumi_i(yumi), .count_o(cnt), .almost_full_o(af)
   );

   logic [W-1:0] q [$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  n_acc = 0;
   bit  s_vo, s_rdy;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // one cycle: check model vs DUT at negedge, drive, update model at posedge
   task automatic step(input bit want_v, input bit want_y, input logic [W-1:0] d);
      bit acc;
      bit pop;
      @(negedge clk);
      s_vo  = v_out;
      s_rdy = ready;
      check("count_o", W'(cnt), W'(q.size()));
      check("almost_full_o", W'(af), W'(q.size() >= AF));
      if (q.size() == 0) check("v_o_when_empty", W'(v_out), W'(0));
      v_in = want_v;
      din  = d;
      yumi = want_y && v_out;
      pop  = yumi && (q.size() != 0);
      if (pop) check("data_o", dout, q[0]);
      acc = v_in && ready;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) begin
         q.push_back(d);
         n_acc++;
      end
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (q.size() != 0 && k < budget) begin
         step(1'b0, 1'b1, '0);
         k++;
      end
      check("drain_complete_words_left", W'(q.size()), W'(0));
      step(1'b0, 1'b0, '0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k;
      bit  stalled;
      reset = 1'b1; v_in = 1'b0; yumi = 1'b0; din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_ready", W'(ready), W'(1));
      check("reset_v_o", W'(v_out), W'(0));
      check("reset_count", W'(cnt), W'(0));
      check("reset_almost_full", W'(af), W'(0));

      // single word, bypass latency of two cycles
      step(1'b1, 1'b1, W'(8'hA5));
      step(1'b0, 1'b1, '0);
      check("t1_v_o_at_t0p1", W'(s_vo), W'(0));
      step(1'b0, 1'b1, '0);
      check("t1_v_o_at_t0p2", W'(s_vo), W'(1));
      step(1'b0, 1'b0, '0);

      // continuous stream with continuous consumption
      for (int i = 1; i <= 2000; i++) begin
         step(1'b1, 1'b1, W'(i));
         check("t2_ready_high", W'(s_rdy), W'(1));
      end
      drain(200);

      // fill without consumption until backpressure
      n_acc = 0; k = 0; stalled = 1'b0;
      while (!stalled && k < 1000) begin
         step(1'b1, 1'b0, rnd());
         if (!s_rdy) stalled = 1'b1;
         k++;
      end
      check("t3_ready_dropped", W'(stalled), W'(1));
      check("t3_min_capacity", W'(n_acc >= ELS + WAYS), W'(1));
      check("t3_count_bound", W'(cnt <= CW'(ELS + 3*WAYS)), W'(1));
      repeat (4) begin
         step(1'b1, 1'b0, rnd());
         check("t3_ready_stays_low", W'(s_rdy), W'(0));
      end
      drain(3000);

      // random 50/50 traffic
      repeat (4000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd());
      drain(3000);

      // 90% in / 60% out, several memory wraps
      n_acc = 0; k = 0;
      while (n_acc < 5*ELS && k < 20000) begin
         step($urandom_range(0, 9) < 9, $urandom_range(0, 9) < 6, rnd());
         k++;
      end
      check("t5_words_accepted", W'(n_acc >= 5*ELS), W'(1));
      drain(3000);

      // reset with data buffered
      k = 0;
      while (q.size() < 300 && k < 400) begin
         step(1'b1, 1'b0, rnd());
         k++;
      end
      check("t6_buffered_300", W'(q.size() >= 300), W'(1));
      @(negedge clk);
      reset = 1'b1; v_in = 1'b0; yumi = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      check("t6_v_o_after_reset", W'(v_out), W'(0));
      check("t6_count_after_reset", W'(cnt), W'(0));
      check("t6_ready_after_reset", W'(ready), W'(1));
      step(1'b1, 1'b1, W'(1));
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      check("t6_first_word_valid", W'(s_vo), W'(1));
      drain(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
